// File: rtl/pixel_plot_sink.sv
`default_nettype none
// ============================================================================
// Module      : pixel_plot_sink
// Description : Buffers pixel plots in a small FIFO and turns them into
//               frame-buffer writes; also performs a whole-frame clear fill.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_plot_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        busy,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_wren,
    output logic [7:0]  drop_count,
    output logic        overflow
);

    localparam int          c_AW         = $clog2(FIFO_DEPTH);
    localparam int          c_EW         = 20;
    localparam logic [9:0]  c_SCREEN_W   = 10'(SCREEN_W);
    localparam logic [8:0]  c_SCREEN_H   = 9'(SCREEN_H);
    localparam logic [16:0] c_CLEAR_LAST = 17'(SCREEN_W * SCREEN_H - 1);
    localparam logic [c_AW:0] c_PTR_ONE  = (c_AW+1)'(1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wrPtr;
    logic [c_AW:0]      r_rdPtr;
    logic               r_clearPending;
    logic [2:0]         r_clearColour;
    logic [16:0]        r_clearAddr;
    logic [16:0]        r_fbAddr;
    logic [2:0]         r_fbData;
    logic               r_fbWren;
    logic [7:0]         r_dropCount;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [c_EW-1:0]    w_head;
    logic [8:0]         w_headX;
    logic [7:0]         w_headY;
    logic [2:0]         w_headCol;
    logic               w_inRange;
    logic [16:0]        w_headAddr;

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                     (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);

    assign ready   = !w_full && !r_clearPending && (r_state == RUN);
    assign busy    = !w_empty || r_fbWren || r_clearPending || (r_state == CLEAR);

    assign w_push  = plot && ready;
    assign w_pop   = (r_state == RUN) && !w_empty;

    assign w_head    = r_mem[r_rdPtr[c_AW-1:0]];
    assign w_headX   = w_head[19:11];
    assign w_headY   = w_head[10:3];
    assign w_headCol = w_head[2:0];
    assign w_inRange = ({1'b0, w_headX} < c_SCREEN_W) && ({1'b0, w_headY} < c_SCREEN_H);

    // y*320 + x as shift-add; worst case 255*320+511 still fits in 17 bits
    assign w_headAddr = {1'b0, w_headY, 8'b0} + {3'b0, w_headY, 6'b0} + {8'b0, w_headX};

    assign fb_addr    = r_fbAddr;
    assign fb_data    = r_fbData;
    assign fb_wren    = r_fbWren;
    assign drop_count = r_dropCount;
    assign overflow   = r_overflow;

    // Storage carries no reset; validity is defined purely by the pointers
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr[c_AW-1:0]] <= {x, y, colour};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= RUN;
            r_wrPtr        <= '0;
            r_rdPtr        <= '0;
            r_clearPending <= 1'b0;
            r_clearColour  <= 3'd0;
            r_clearAddr    <= 17'd0;
            r_fbAddr       <= 17'd0;
            r_fbData       <= 3'd0;
            r_fbWren       <= 1'b0;
            r_dropCount    <= 8'd0;
            r_overflow     <= 1'b0;
        end else begin
            r_fbWren <= 1'b0;

            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (plot && !ready) begin
                r_overflow <= 1'b1;
            end

            if (r_state == RUN) begin
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + c_PTR_ONE;
                    if (w_inRange) begin
                        r_fbWren <= 1'b1;
                        r_fbAddr <= w_headAddr;
                        r_fbData <= w_headCol;
                    end else if (r_dropCount != 8'hFF) begin
                        r_dropCount <= r_dropCount + 8'd1;
                    end
                end
                // Clear waits until every queued pixel has left the output register
                if (r_clearPending) begin
                    if (w_empty && !r_fbWren) begin
                        r_state     <= CLEAR;
                        r_clearAddr <= 17'd0;
                    end
                end else if (clear_req) begin
                    r_clearPending <= 1'b1;
                    r_clearColour  <= clear_colour;
                end
            end else begin
                r_fbWren <= 1'b1;
                r_fbAddr <= r_clearAddr;
                r_fbData <= r_clearColour;
                if (r_clearAddr == c_CLEAR_LAST) begin
                    r_state        <= RUN;
                    r_clearPending <= 1'b0;
                end else begin
                    r_clearAddr <= r_clearAddr + 17'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_plot_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_plot_sink
// Description : Directed self-checking bench for pixel_plot_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_plot_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        ready;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        busy;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_wren;
    logic [7:0]  drop_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    pixel_plot_sink #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (320),
        .SCREEN_H   (240)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .ready        (ready),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_wren      (fb_wren),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (ready !== 1'b1)       begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fb_wren !== 1'b0)     begin errors++; $display("FAIL rst_wren: got %b want 0", fb_wren); end
        checks++; if (fb_addr !== 17'd0)    begin errors++; $display("FAIL rst_addr: got %0d want 0", fb_addr); end
        checks++; if (drop_count !== 8'd0)  begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        resetn = 1'b1;
        step();
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || fb_wren !== 1'b0) begin
            errors++; $display("FAIL rel_state: got ready=%b busy=%b wren=%b want 1/0/0", ready, busy, fb_wren);
        end
    endtask

    task automatic test_single_plot();
        plot = 1'b1; x = 9'd5; y = 8'd2; colour = 3'b101;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sp_ready: got %b want 1", ready); end
        step();
        plot = 1'b0;
        checks++; if (fb_wren !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL sp_edgeN: got wren=%b busy=%b want 0/1", fb_wren, busy);
        end
        step();
        checks++; if (fb_wren !== 1'b1) begin errors++; $display("FAIL sp_wren: got %b want 1", fb_wren); end
        checks++; if (fb_addr !== 17'd645) begin errors++; $display("FAIL sp_addr: got %0d want 645", fb_addr); end
        checks++; if (fb_data !== 3'd5) begin errors++; $display("FAIL sp_data: got %0d want 5", fb_data); end
        step();
        checks++; if (fb_wren !== 1'b0 || fb_addr !== 17'd645 || busy !== 1'b0) begin
            errors++; $display("FAIL sp_after: got wren=%b addr=%0d busy=%b want 0/645/0", fb_wren, fb_addr, busy);
        end
    endtask

    task automatic test_range();
        int n;
        logic [16:0] a;
        logic [2:0]  d;
        logic [8:0]  xs [3];
        logic [7:0]  ys [3];
        n = 0; a = '0; d = '0;
        xs[0] = 9'd319; ys[0] = 8'd239;
        xs[1] = 9'd320; ys[1] = 8'd0;
        xs[2] = 9'd0;   ys[2] = 8'd240;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                plot = 1'b1; x = xs[i]; y = ys[i]; colour = 3'd1;
            end else begin
                plot = 1'b0;
            end
            step();
            if (fb_wren === 1'b1) begin n++; a = fb_addr; d = fb_data; end
        end
        plot = 1'b0;
        checks++; if (n != 1) begin errors++; $display("FAIL rg_count: got %0d writes want 1", n); end
        checks++; if (a !== 17'd76799 || d !== 3'd1) begin
            errors++; $display("FAIL rg_write: got addr=%0d data=%0d want 76799/1", a, d);
        end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL rg_drop: got %0d want 2", drop_count); end
    endtask

    task automatic test_clear();
        int k;
        int cyc;
        int bad;
        int gaps;
        logic [16:0] ea;
        logic [2:0]  ed;
        k = 0; cyc = 0; bad = 0; gaps = 0;
        plot = 1'b1; x = 9'd10; y = 8'd1; colour = 3'd3;
        step();
        x = 9'd20; colour = 3'd4; clear_req = 1'b1; clear_colour = 3'b010;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cl_ready: got %b want 1", ready); end
        step();
        plot = 1'b0; clear_req = 1'b0;
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL cl_pending: got busy=%b ready=%b want 1/0", busy, ready);
        end
        while (k < 76802 && cyc < 80000) begin
            if (fb_wren === 1'b1) begin
                if (k == 0)      begin ea = 17'd330; ed = 3'd3; end
                else if (k == 1) begin ea = 17'd340; ed = 3'd4; end
                else             begin ea = 17'(k - 2); ed = 3'd2; end
                if (fb_addr !== ea || fb_data !== ed) begin
                    if (bad == 0) $display("FAIL cl_seq: write %0d got addr=%0d data=%0d want %0d/%0d", k, fb_addr, fb_data, ea, ed);
                    bad++;
                end
                k++;
            end else if (k >= 3) begin
                gaps++;
            end
            if (k < 76802) begin step(); cyc++; end
        end
        checks++; if (k != 76802) begin errors++; $display("FAIL cl_total: got %0d writes want 76802", k); end
        checks++; if (bad != 0) begin errors++; $display("FAIL cl_values: got %0d bad writes want 0", bad); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL cl_gaps: got %0d idle cycles want 0", gaps); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cl_busy_last: got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b0 || fb_wren !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL cl_done: got busy=%b wren=%b ready=%b want 0/0/1", busy, fb_wren, ready);
        end
    endtask

    task automatic test_overflow_abort();
        int k;
        int cyc;
        int n;
        bit tried;
        bit ovDone;
        k = 0; cyc = 0; n = 0; tried = 0; ovDone = 0;
        clear_req = 1'b1; clear_colour = 3'd6;
        step();
        clear_req = 1'b0;
        while (k < 1000 && cyc < 2000) begin
            step();
            cyc++;
            plot = 1'b0;
            if (fb_wren === 1'b1) k++;
            if (tried && !ovDone) begin
                ovDone = 1;
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b want 1", overflow); end
            end
            if (k == 500 && !tried) begin
                tried = 1;
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ov_ready: got %b want 0", ready); end
                plot = 1'b1; x = 9'd7; y = 8'd7; colour = 3'd1;
            end
        end
        checks++; if (k != 1000) begin errors++; $display("FAIL ab_reach: got %0d writes want 1000", k); end
        resetn = 1'b0;
        #1;
        checks++; if (fb_wren !== 1'b0 || fb_addr !== 17'd0) begin
            errors++; $display("FAIL ab_wren: got wren=%b addr=%0d want 0/0", fb_wren, fb_addr);
        end
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL ab_state: got ready=%b busy=%b ovf=%b want 1/0/0", ready, busy, overflow);
        end
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fb_wren === 1'b1) n++;
        end
        checks++; if (n != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL ab_resume: got %0d writes busy=%b want 0/0", n, busy);
        end
    endtask

    task automatic test_drop_saturation();
        int n;
        n = 0;
        plot = 1'b1; x = 9'd400; y = 8'd0; colour = 3'd7;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (fb_wren === 1'b1) n++;
            if (i == 100) begin
                checks++; if (drop_count !== 8'd99) begin errors++; $display("FAIL ds_mid: got %0d want 99", drop_count); end
            end
        end
        plot = 1'b0;
        repeat (3) begin
            step();
            if (fb_wren === 1'b1) n++;
        end
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL ds_sat: got %0d want 255", drop_count); end
        checks++; if (n != 0 || overflow !== 1'b0) begin
            errors++; $display("FAIL ds_side: got writes=%0d ovf=%b want 0/0", n, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single_plot();
        test_range();
        test_clear();
        test_overflow_abort();
        test_drop_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
